// File: rtl/inst_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : inst_sequencer_pkg
// Description : Core instruction field positions, idle word and FSM states.
// Revision    : 1.0
// ============================================================================
package inst_sequencer_pkg;

    localparam int c_ADDR_W = 11;

    localparam int c_BIT_LOAD        = 0;
    localparam int c_BIT_EXECUTE     = 1;
    localparam int c_BIT_L0_WR       = 2;
    localparam int c_BIT_L0_RD       = 3;
    localparam int c_BIT_OFIFO_RD    = 6;
    localparam int c_A_XMEM_LSB      = 7;
    localparam int c_BIT_WEN_XMEM    = 18;
    localparam int c_BIT_CEN_XMEM    = 19;
    localparam int c_A_PMEM_LSB      = 20;
    localparam int c_BIT_WEN_PMEM    = 31;
    localparam int c_BIT_CEN_PMEM    = 32;
    localparam int c_BIT_ACC         = 33;
    localparam int c_BIT_PASSTHROUGH = 34;
    localparam int c_BIT_REN_PMEM    = 35;

    // Both SRAMs deselected with write-enable high (bits 32, 31, 19, 18).
    localparam logic [63:0] c_IDLE_WORD = 64'h0000_0001_800C_0000;

    localparam logic [3:0] c_ST_IDLE = 4'd0;
    localparam logic [3:0] c_ST_WRD  = 4'd1;
    localparam logic [3:0] c_ST_WLD  = 4'd2;
    localparam logic [3:0] c_ST_ARD  = 4'd3;
    localparam logic [3:0] c_ST_EXE  = 4'd4;
    localparam logic [3:0] c_ST_DRN  = 4'd5;
    localparam logic [3:0] c_ST_PRD  = 4'd6;
    localparam logic [3:0] c_ST_PWR  = 4'd7;
    localparam logic [3:0] c_ST_FIN  = 4'd8;

endpackage
`default_nettype wire

// File: rtl/xmem_burst.sv
`default_nettype none
// ============================================================================
// Module      : xmem_burst
// Description : xmem read address and one-cycle-delayed l0_wr for a burst.
// Revision    : 1.0
// ============================================================================
module xmem_burst
    import inst_sequencer_pkg::*;
#(
    parameter int IDX_W = 12
) (
    input  logic [IDX_W-1:0]    idx_i,
    input  logic [IDX_W-1:0]    len_i,
    input  logic [c_ADDR_W-1:0] base_i,
    output logic                rd_en_o,
    output logic [c_ADDR_W-1:0] addr_o,
    output logic                l0_wr_o
);

    // Reads occupy idx 0..len-1; l0_wr trails them at idx 1..len.
    assign rd_en_o = (idx_i < len_i);
    assign addr_o  = base_i + idx_i[c_ADDR_W-1:0];
    assign l0_wr_o = (idx_i != '0) && (idx_i <= len_i);

endmodule
`default_nettype wire

// File: rtl/inst_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : inst_sequencer
// Description : Weight-stationary tile-pass sequencer driving the core inst word.
// Revision    : 1.0
// ============================================================================
module inst_sequencer
    import inst_sequencer_pkg::*;
#(
    parameter int ROW = 8,
    parameter int COL = 8,
    parameter int TMO = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [10:0] n_act,
    input  logic [10:0] w_base,
    input  logic [10:0] a_base,
    input  logic [10:0] p_base,
    input  logic        acc_en,
    input  logic        ofifo_valid,
    output logic [63:0] inst,
    output logic        busy,
    output logic        done,
    output logic        err
);

    logic [3:0]  state_q, state_d;
    logic [11:0] cnt_q, cnt_d;
    logic [10:0] k_q, k_d, n_q, n_d;
    logic [10:0] wb_q, wb_d, ab_q, ab_d, pb_q, pb_d;
    logic        acc_q, acc_d, rd_q, rd_d, err_q, err_d;
    logic [63:0] inst_q, inst_d;
    logic        busy_q, done_q;

    logic        w_wrd_rd, w_wrd_l0, w_ard_rd, w_ard_l0;
    logic [10:0] w_wrd_addr, w_ard_addr;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        n_d     = n_q;
        wb_d    = wb_q;
        ab_d    = ab_q;
        pb_d    = pb_q;
        acc_d   = acc_q;
        rd_d    = rd_q;
        err_d   = err_q;
        case (state_q)
            c_ST_IDLE: if (start) begin
                n_d     = n_act;
                wb_d    = w_base;
                ab_d    = a_base;
                pb_d    = p_base;
                acc_d   = acc_en;
                err_d   = 1'b0;
                cnt_d   = '0;
                k_d     = '0;
                rd_d    = 1'b0;
                state_d = (n_act == '0) ? c_ST_FIN : c_ST_WRD;
            end
            c_ST_WRD: if (cnt_q == 12'(ROW)) begin
                state_d = c_ST_WLD;
                cnt_d   = '0;
            end else cnt_d = cnt_q + 12'd1;
            c_ST_WLD: if (cnt_q == 12'(COL)) begin
                state_d = c_ST_ARD;
                cnt_d   = '0;
            end else cnt_d = cnt_q + 12'd1;
            c_ST_ARD: if (cnt_q == {1'b0, n_q}) begin
                state_d = c_ST_EXE;
                cnt_d   = '0;
            end else cnt_d = cnt_q + 12'd1;
            c_ST_EXE: if (cnt_q == {1'b0, n_q} - 12'd1) begin
                state_d = c_ST_DRN;
                cnt_d   = '0;
            end else cnt_d = cnt_q + 12'd1;
            c_ST_DRN: if (ofifo_valid) begin
                state_d = c_ST_PRD;
                cnt_d   = '0;
                k_d     = '0;
                rd_d    = 1'b1;
            end else if (cnt_q == 12'(TMO - 1)) begin
                state_d = c_ST_FIN;
                cnt_d   = '0;
                err_d   = 1'b1;
            end else cnt_d = cnt_q + 12'd1;
            // rd_q marks a PRD cycle that actually issued the pmem read.
            c_ST_PRD: if (rd_q) begin
                state_d = c_ST_PWR;
                rd_d    = 1'b0;
            end else rd_d = ofifo_valid;
            c_ST_PWR: if (k_q == n_q - 11'd1) begin
                state_d = c_ST_FIN;
            end else begin
                state_d = c_ST_PRD;
                k_d     = k_q + 11'd1;
                rd_d    = ofifo_valid;
            end
            c_ST_FIN: state_d = c_ST_IDLE;
            default:  state_d = c_ST_IDLE;
        endcase
    end

    xmem_burst #(.IDX_W(12)) u_wrd_burst (
        .idx_i   (cnt_d),
        .len_i   (12'(ROW)),
        .base_i  (wb_d),
        .rd_en_o (w_wrd_rd),
        .addr_o  (w_wrd_addr),
        .l0_wr_o (w_wrd_l0)
    );

    xmem_burst #(.IDX_W(12)) u_ard_burst (
        .idx_i   (cnt_d),
        .len_i   ({1'b0, n_d}),
        .base_i  (ab_d),
        .rd_en_o (w_ard_rd),
        .addr_o  (w_ard_addr),
        .l0_wr_o (w_ard_l0)
    );

    // The word is built from next-state values so inst lines up with state_q.
    always_comb begin
        inst_d = c_IDLE_WORD;
        case (state_d)
            c_ST_WRD: begin
                if (w_wrd_rd) begin
                    inst_d[c_BIT_CEN_XMEM]                = 1'b0;
                    inst_d[c_A_XMEM_LSB +: c_ADDR_W]      = w_wrd_addr;
                end
                inst_d[c_BIT_L0_WR] = w_wrd_l0;
            end
            c_ST_WLD: if (cnt_d < 12'(COL)) begin
                inst_d[c_BIT_LOAD]  = 1'b1;
                inst_d[c_BIT_L0_RD] = 1'b1;
            end
            c_ST_ARD: begin
                if (w_ard_rd) begin
                    inst_d[c_BIT_CEN_XMEM]                = 1'b0;
                    inst_d[c_A_XMEM_LSB +: c_ADDR_W]      = w_ard_addr;
                end
                inst_d[c_BIT_L0_WR] = w_ard_l0;
            end
            c_ST_EXE: begin
                inst_d[c_BIT_EXECUTE] = 1'b1;
                inst_d[c_BIT_L0_RD]   = 1'b1;
            end
            c_ST_PRD: if (rd_d) begin
                inst_d[c_BIT_CEN_PMEM]           = 1'b0;
                inst_d[c_BIT_REN_PMEM]           = 1'b1;
                inst_d[c_A_PMEM_LSB +: c_ADDR_W] = pb_d + k_d;
            end
            c_ST_PWR: begin
                inst_d[c_BIT_CEN_PMEM]           = 1'b0;
                inst_d[c_BIT_WEN_PMEM]           = 1'b0;
                inst_d[c_A_PMEM_LSB +: c_ADDR_W] = pb_d + k_d;
                inst_d[c_BIT_OFIFO_RD]           = 1'b1;
                inst_d[c_BIT_ACC]                = acc_d;
                inst_d[c_BIT_PASSTHROUGH]        = ~acc_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= c_ST_IDLE;
            cnt_q   <= '0;
            k_q     <= '0;
            n_q     <= '0;
            wb_q    <= '0;
            ab_q    <= '0;
            pb_q    <= '0;
            acc_q   <= 1'b0;
            rd_q    <= 1'b0;
            err_q   <= 1'b0;
            inst_q  <= c_IDLE_WORD;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            n_q     <= n_d;
            wb_q    <= wb_d;
            ab_q    <= ab_d;
            pb_q    <= pb_d;
            acc_q   <= acc_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
            inst_q  <= inst_d;
            busy_q  <= (state_d != c_ST_IDLE);
            done_q  <= (state_d == c_ST_FIN);
        end
    end

    assign inst = inst_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_sequencer
// Description : Scoreboard bench for inst_sequencer tile passes.
// Revision    : 1.0
// ============================================================================
module tb_inst_sequencer;

    localparam logic [63:0] IDLE_W = 64'h0000_0001_800C_0000;

    logic        clk = 1'b0;
    logic        reset, start, acc_en, ofifo_valid;
    logic [10:0] n_act, w_base, a_base, p_base;
    logic [63:0] inst;
    logic        busy, done, err;

    int n_cmp = 0;
    int n_fail = 0;
    int tcur = 0;
    int n_load = 0;
    int n_exe = 0;
    int rsv_bad = 0;

    // xmem entry {WEN_xmem, A_xmem}; pmem entry {WEN, REN, ofifo_rd, acc, passthrough, A_pmem}
    logic [11:0] exp_x[$], obs_x[$];
    logic [15:0] exp_p[$], obs_p[$];
    int          obs_xt[$], obs_lt[$];

    always #5 clk = ~clk;

    inst_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .n_act       (n_act),
        .w_base      (w_base),
        .a_base      (a_base),
        .p_base      (p_base),
        .acc_en      (acc_en),
        .ofifo_valid (ofifo_valid),
        .inst        (inst),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    function automatic logic [15:0] rd_ent(input logic [10:0] a);
        return {5'b11000, a};
    endfunction

    function automatic logic [15:0] wr_ent(input logic acc, input logic [10:0] a);
        return {3'b001, acc, ~acc, a};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        tcur++;
        if (inst[19] == 1'b0) begin
            obs_x.push_back({inst[18], inst[17:7]});
            obs_xt.push_back(tcur);
        end
        if (inst[2]) obs_lt.push_back(tcur);
        if (inst[0]) n_load++;
        if (inst[1]) n_exe++;
        if (inst[32] == 1'b0)
            obs_p.push_back({inst[31], inst[35], inst[6], inst[33], inst[34], inst[30:20]});
        if (inst[63:36] != '0 || inst[5:4] != '0) rsv_bad++;
    endtask

    task automatic launch(input logic [10:0] n, input logic [10:0] wb, input logic [10:0] ab,
                          input logic [10:0] pb, input logic acc, input int poke,
                          output int done_at, output int err_at);
        obs_x.delete(); obs_p.delete(); obs_xt.delete(); obs_lt.delete();
        n_load = 0; n_exe = 0; tcur = 0;
        done_at = -1; err_at = -1;
        n_act = n; w_base = wb; a_base = ab; p_base = pb; acc_en = acc;
        start = 1'b1;
        while (done_at < 0 && tcur < 3000) begin
            tick();
            start = 1'b0;
            if (err === 1'b1 && err_at < 0) err_at = tcur;
            if (done === 1'b1) done_at = tcur;
            if (tcur == poke) begin
                start = 1'b1; n_act = 11'd1; p_base = 11'd500;
                w_base = 11'd7; a_base = 11'd9; acc_en = 1'b1;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; ofifo_valid = 1'b1; acc_en = 1'b0;
        n_act = '0; w_base = '0; a_base = '0; p_base = '0;
        repeat (3) tick();
        n_cmp++; if (inst !== IDLE_W) begin n_fail++; $display("FAIL reset_inst: got %h want %h", inst, IDLE_W); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_nominal(input string tag);
        int d, e;
        logic lag_ok;
        for (int i = 0; i < 8; i++) exp_x.push_back({1'b1, 11'(i)});
        for (int i = 16; i < 20; i++) exp_x.push_back({1'b1, 11'(i)});
        for (int i = 0; i < 4; i++) begin
            exp_p.push_back(rd_ent(11'(100 + i)));
            exp_p.push_back(wr_ent(1'b0, 11'(100 + i)));
        end
        ofifo_valid = 1'b1;
        launch(11'd4, 11'd0, 11'd16, 11'd100, 1'b0, -1, d, e);
        n_cmp++; if (d != 37) begin n_fail++; $display("FAIL %s_done_cycle: got %0d want 37", tag, d); end
        lag_ok = (obs_lt.size() == obs_xt.size());
        for (int i = 0; i < obs_lt.size() && i < obs_xt.size(); i++)
            if (obs_lt[i] != obs_xt[i] + 1) lag_ok = 1'b0;
        n_cmp++; if (!lag_ok) begin n_fail++; $display("FAIL %s_l0wr_lag: got %0d l0_wr vs %0d reads, want one-cycle lag", tag, obs_lt.size(), obs_xt.size()); end
        n_cmp++; if (n_load != 8) begin n_fail++; $display("FAIL %s_load_cycles: got %0d want 8", tag, n_load); end
        n_cmp++; if (n_exe != 4) begin n_fail++; $display("FAIL %s_exe_cycles: got %0d want 4", tag, n_exe); end
        while (exp_x.size() > 0 && obs_x.size() > 0) begin
            logic [11:0] ev, ov;
            ev = exp_x.pop_front(); ov = obs_x.pop_front();
            n_cmp++; if (ov !== ev) begin n_fail++; $display("FAIL %s_xmem_rd: got %h want %h", tag, ov, ev); end
        end
        n_cmp++; if (exp_x.size() != 0 || obs_x.size() != 0) begin n_fail++; $display("FAIL %s_xmem_count: left exp %0d obs %0d want 0 0", tag, exp_x.size(), obs_x.size()); end
        while (exp_p.size() > 0 && obs_p.size() > 0) begin
            logic [15:0] ev, ov;
            ev = exp_p.pop_front(); ov = obs_p.pop_front();
            n_cmp++; if (ov !== ev) begin n_fail++; $display("FAIL %s_pmem_op: got %h want %h", tag, ov, ev); end
        end
        n_cmp++; if (exp_p.size() != 0 || obs_p.size() != 0) begin n_fail++; $display("FAIL %s_pmem_count: left exp %0d obs %0d want 0 0", tag, exp_p.size(), obs_p.size()); end
        exp_x.delete(); exp_p.delete();
        tick();
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL %s_after_done: got busy %b done %b want 0 0", tag, busy, done); end
    endtask

    task automatic test_acc_wrap();
        int d, e;
        logic [10:0] a;
        a = 11'd2044;
        repeat (8) begin exp_x.push_back({1'b1, a}); a = a + 11'd1; end
        a = 11'd2046;
        repeat (3) begin
            exp_x.push_back({1'b1, a});
            exp_p.push_back(rd_ent(a));
            exp_p.push_back(wr_ent(1'b1, a));
            a = a + 11'd1;
        end
        ofifo_valid = 1'b1;
        launch(11'd3, 11'd2044, 11'd2046, 11'd2046, 1'b1, -1, d, e);
        n_cmp++; if (d != 33) begin n_fail++; $display("FAIL wrap_done_cycle: got %0d want 33", d); end
        while (exp_x.size() > 0 && obs_x.size() > 0) begin
            logic [11:0] ev, ov;
            ev = exp_x.pop_front(); ov = obs_x.pop_front();
            n_cmp++; if (ov !== ev) begin n_fail++; $display("FAIL wrap_xmem_rd: got %h want %h", ov, ev); end
        end
        n_cmp++; if (exp_x.size() != 0 || obs_x.size() != 0) begin n_fail++; $display("FAIL wrap_xmem_count: left exp %0d obs %0d want 0 0", exp_x.size(), obs_x.size()); end
        while (exp_p.size() > 0 && obs_p.size() > 0) begin
            logic [15:0] ev, ov;
            ev = exp_p.pop_front(); ov = obs_p.pop_front();
            n_cmp++; if (ov !== ev) begin n_fail++; $display("FAIL wrap_pmem_op: got %h want %h", ov, ev); end
        end
        n_cmp++; if (exp_p.size() != 0 || obs_p.size() != 0) begin n_fail++; $display("FAIL wrap_pmem_count: left exp %0d obs %0d want 0 0", exp_p.size(), obs_p.size()); end
        exp_x.delete(); exp_p.delete();
        tick();
    endtask

    task automatic test_busy_start();
        int d, e;
        for (int i = 0; i < 4; i++) begin
            exp_p.push_back(rd_ent(11'(100 + i)));
            exp_p.push_back(wr_ent(1'b0, 11'(100 + i)));
        end
        ofifo_valid = 1'b1;
        launch(11'd4, 11'd0, 11'd16, 11'd100, 1'b0, 25, d, e);
        n_cmp++; if (d != 37) begin n_fail++; $display("FAIL busy_done_cycle: got %0d want 37", d); end
        while (exp_p.size() > 0 && obs_p.size() > 0) begin
            logic [15:0] ev, ov;
            ev = exp_p.pop_front(); ov = obs_p.pop_front();
            n_cmp++; if (ov !== ev) begin n_fail++; $display("FAIL busy_pmem_op: got %h want %h", ov, ev); end
        end
        n_cmp++; if (exp_p.size() != 0 || obs_p.size() != 0) begin n_fail++; $display("FAIL busy_pmem_count: left exp %0d obs %0d want 0 0", exp_p.size(), obs_p.size()); end
        exp_p.delete();
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_restart: got busy %b want 0", busy); end
    endtask

    task automatic test_timeout();
        int d, e;
        ofifo_valid = 1'b0;
        // N=2: DRN is entered on cycle 9+9+3+2+1 = 24, err 1023 cycles later
        launch(11'd2, 11'd0, 11'd16, 11'd100, 1'b0, -1, d, e);
        n_cmp++; if (e != 1047) begin n_fail++; $display("FAIL tmo_err_cycle: got %0d want 1047", e); end
        n_cmp++; if (d != 1047) begin n_fail++; $display("FAIL tmo_done_cycle: got %0d want 1047", d); end
        n_cmp++; if (obs_p.size() != 0) begin n_fail++; $display("FAIL tmo_pmem_access: got %0d want 0", obs_p.size()); end
        repeat (3) tick();
        n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL tmo_err_sticky: got %b want 1", err); end
        ofifo_valid = 1'b1;
    endtask

    task automatic test_n_zero();
        int d, e;
        ofifo_valid = 1'b1;
        launch(11'd0, 11'd5, 11'd6, 11'd7, 1'b1, -1, d, e);
        n_cmp++; if (d != 1) begin n_fail++; $display("FAIL n0_done_cycle: got %0d want 1", d); end
        n_cmp++; if (e != -1) begin n_fail++; $display("FAIL n0_err_cleared: err seen at %0d want never", e); end
        n_cmp++; if (obs_x.size() != 0 || obs_p.size() != 0) begin n_fail++; $display("FAIL n0_mem_access: got xmem %0d pmem %0d want 0 0", obs_x.size(), obs_p.size()); end
        tick();
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL n0_after: got busy %b done %b want 0 0", busy, done); end
    endtask

    task automatic test_reset_midrun();
        logic hit;
        obs_p.delete(); tcur = 0; hit = 1'b0;
        ofifo_valid = 1'b1; n_act = 11'd4; w_base = 11'd0; a_base = 11'd16;
        p_base = 11'd100; acc_en = 1'b0; start = 1'b1;
        for (int i = 0; i < 100 && !hit; i++) begin
            tick();
            start = 1'b0;
            if (inst[32] == 1'b0 && inst[31] == 1'b0 && inst[30:20] == 11'd101) hit = 1'b1;
        end
        n_cmp++; if (!hit) begin n_fail++; $display("FAIL midrun_reach_pwr: got 0 want 1"); end
        reset = 1'b1;
        tick();
        n_cmp++; if (inst !== IDLE_W) begin n_fail++; $display("FAIL midrun_inst: got %h want %h", inst, IDLE_W); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrun_busy: got %b want 0", busy); end
        reset = 1'b0;
        repeat (3) tick();
        n_cmp++; if (obs_p.size() != 4) begin n_fail++; $display("FAIL midrun_pmem_ops: got %0d want 4", obs_p.size()); end
        test_nominal("post_reset");
    endtask

    task automatic test_reserved_bits();
        n_cmp++; if (rsv_bad != 0) begin n_fail++; $display("FAIL reserved_bits: got %0d cycles set want 0", rsv_bad); end
    endtask

    initial begin
        test_reset();
        test_nominal("nominal");
        test_acc_wrap();
        test_busy_start();
        test_timeout();
        test_n_zero();
        test_reset_midrun();
        test_reserved_bits();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/inst_sequencer.md
INST_SEQUENCER -- requirements
Module: inst_sequencer

Interface
REQ-001 Parameters: row, default 8, number of L0 rows and PE rows; col, default 8, number of PE columns; tmo, default 1023, drain timeout in cycles.
REQ-002 clk  input  1  single clock; all logic rises on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle pulse that launches one tile pass; ignored unless the state is IDLE.
REQ-005 n_act  input  11  activation vector count N, sampled at start.
REQ-006 w_base, a_base, p_base  input  11 each  xmem weight base, xmem activation base and pmem psum base, sampled at start.
REQ-007 acc_en  input  1  sampled at start; 1 = accumulate into pmem, 0 = overwrite (passthrough).
REQ-008 ofifo_valid  input  1  core output-FIFO valid flag.
REQ-009 inst  output  64  registered core instruction word, using the core field map (l1_wr[37], output_stationary[36], REN_pmem[35], passthrough[34], acc[33], CEN_pmem[32], WEN_pmem[31], A_pmem[30:20], CEN_xmem[19], WEN_xmem[18], A_xmem[17:7], ofifo_rd[6], ififo_wr[5], ififo_rd[4], l0_rd[3], l0_wr[2], execute[1], load[0]).
REQ-010 busy, done, err  output  1 each  busy = pass in progress; done = one-cycle completion pulse; err = sticky drain timeout, cleared by start.

Function
REQ-011 Idle word: CEN_xmem=1, WEN_xmem=1, CEN_pmem=1, WEN_pmem=1; all other bits 0; driven in every cycle not specified below.
REQ-012 Bits 63, 38–62, 36, 37, 5 and 4 are always 0 (weight-stationary only; no IFIFO, no L1).
REQ-013 States: IDLE, WRD, WLD, ARD, EXE, DRN, PRD, PWR, FIN.
REQ-014 IDLE→WRD on start with N≥1; IDLE→FIN on start with N=0, with no xmem or pmem access.
REQ-015 WRD: issues row xmem reads (CEN_xmem=0, WEN_xmem=1, A_xmem=w_base+i, i=0..row-1).
REQ-016 WRD: l0_wr is asserted one cycle after each read to cover SRAM read latency, so WRD lasts row+1 cycles.
REQ-017 WLD: load=1 and l0_rd=1 for col cycles, then one cycle with load=0; then →ARD.
REQ-018 ARD: same pattern as WRD, with N reads at a_base+j and N+1 cycles.
REQ-019 EXE: execute=1 and l0_rd=1 for N cycles; then →DRN.
REQ-020 DRN: waits for ofifo_valid=1, then →PRD with vector index k=0.
REQ-021 DRN: if tmo cycles elapse without ofifo_valid, err is set and the FSM →FIN.
REQ-022 PRD: CEN_pmem=0, REN_pmem=1, WEN_pmem=1, A_pmem=p_base+k.
REQ-023 PWR: CEN_pmem=0, WEN_pmem=0, REN_pmem=0, A_pmem=p_base+k, ofifo_rd=1, acc=acc_en, passthrough=~acc_en.
REQ-024 PWR: k<N-1 → k+1, PRD; k=N-1 → FIN.
REQ-025 If ofifo_valid=0 on entry to PRD with k>0, the FSM stalls in PRD with CEN_pmem=1 until ofifo_valid=1.
REQ-026 FIN: done=1 for one cycle, busy=0 next cycle, →IDLE.
REQ-027 busy=1 in every state except IDLE.
REQ-028 Address arithmetic is modulo 2^11, so base+offset wraps past 2047 with no error.
REQ-029 A start pulse while busy has no effect: parameters are not resampled and err is not cleared.

Reset
REQ-030 On reset: state=IDLE, inst=idle word, busy=0, done=0, err=0, all counters 0; this takes effect in the reset cycle regardless of the state.
REQ-031 Reset mid-pass aborts the pass; the next cycle drives the idle word, and no partial pmem write is issued after reset is asserted.

Structure
REQ-032 A shared package holds the inst bit-position constants, the idle-word constant and the state enumeration.
REQ-033 A single sub-module, xmem_burst, generates the read-address and delayed l0_wr sequence and is instanced for both WRD and ARD.

Verification
REQ-034 Reset: assert reset for 3 cycles → inst = idle word (bits 19,18,32,31 set, all others 0); busy=0, done=0, err=0.
REQ-035 Nominal pass: start with N=4, w_base=0, a_base=16, p_base=100, acc_en=0, and ofifo_valid tied 1.
REQ-036 Expected response: A_xmem=0..7 then l0_wr lagging one cycle; 8 load cycles; A_xmem=16..19; 4 execute cycles; pmem writes at 100..103 with passthrough=1; done after 9+9+5+4+1+8+1 cycles.
REQ-037 Accumulate wrap: p_base=2046, N=3, acc_en=1 → PWR addresses 2046, 2047, 0, each with acc=1 and a preceding read of the same address.
REQ-038 Timeout: ofifo_valid held 0 → err=1 exactly tmo cycles after DRN entry, done pulses, and no pmem access occurs.
REQ-039 Busy start / N=0: a second start during EXE changes nothing; start with N=0 → done on the following cycle with CEN_xmem and CEN_pmem never 0.
REQ-040 Reset mid-run: reset in PWR at k=1 → next inst = idle word, busy=0, and a new start runs a complete nominal pass.
